// File: rtl/s2mm_pkg.sv
// s2mm_pkg
// Shared types for the stream-to-memory writer:
//   - s2mm_state_e : writer FSM states (IDLE / RUN / DRAIN)
//   - s2mm_wr_req_t: one memory write request (address, data)
//   - s2mm_cmd_t   : one transfer command (base address, word count)
// The S2MM_* widths are the default build widths and match the
// default parameters of s2mm_writer and s2mm_addr_counter.
package s2mm_pkg;

  localparam int unsigned S2MM_WORD_WIDTH = 32;
  localparam int unsigned S2MM_ADDR_WIDTH = 16;
  localparam int unsigned S2MM_LEN_WIDTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } s2mm_state_e;

  typedef struct packed {
    logic [S2MM_ADDR_WIDTH-1:0] addr;
    logic [S2MM_WORD_WIDTH-1:0] data;
  } s2mm_wr_req_t;

  typedef struct packed {
    logic [S2MM_ADDR_WIDTH-1:0] addr;
    logic [S2MM_LEN_WIDTH-1:0]  len;
  } s2mm_cmd_t;

endpackage

// File: rtl/s2mm_addr_counter.sv
// s2mm_addr_counter
// Loadable write-address register plus remaining-word counter.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   load            : take load_addr / load_len (has priority over step)
//   load_addr       : base word address
//   load_len        : number of words in the transfer
//   step            : one word consumed: addr += 1 (wraps), remaining -= 1
//   addr            : address of the next word to be written
//   remaining       : words still to be accepted
//   zero            : remaining == 0
module s2mm_addr_counter
  import s2mm_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = S2MM_ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH  = S2MM_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [LEN_WIDTH-1:0]  load_len,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [LEN_WIDTH-1:0]  remaining,
  output logic                  zero
);

  logic [ADDR_WIDTH-1:0] addr_r;
  logic [LEN_WIDTH-1:0]  remaining_r;

  // Address / count registers; address wraps naturally at 2^ADDR_WIDTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_r      <= {ADDR_WIDTH{1'b0}};
      remaining_r <= {LEN_WIDTH{1'b0}};
    end else if (load) begin
      addr_r      <= load_addr;
      remaining_r <= load_len;
    end else if (step) begin
      addr_r      <= addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      remaining_r <= remaining_r - {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      addr_r      <= addr_r;
      remaining_r <= remaining_r;
    end
  end

  assign addr      = addr_r;
  assign remaining = remaining_r;
  assign zero      = (remaining_r == {LEN_WIDTH{1'b0}});

endmodule

// File: rtl/s2mm_writer.sv
// s2mm_writer
// Stream-to-memory writer. Accepts a command (base address, word count),
// takes words from a valid/ready stream and issues one memory write per
// word at incrementing addresses through a single-entry output stage.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   i_cmd_valid / o_cmd_ready      : command handshake (ready while IDLE)
//   i_cmd_addr, i_cmd_len          : base word address, word count (0 legal)
//   i_s_valid / o_s_ready          : stream handshake
//   i_s_data, i_s_last             : stream word, end-of-packet marker
//   o_wr_valid / i_wr_ready        : memory write handshake
//   o_wr_addr, o_wr_data           : write address / data
//   o_done                         : one-cycle completion pulse
//   o_err                          : sticky framing error, cleared on command accept
// Build option:
//   S2MM_LAST_CHECK_EN : check i_s_last against the word count; an early
//   last ends the transfer and flags o_err, a missing last on the final
//   counted word flags o_err. Without it i_s_last is ignored and o_err is 0.
module s2mm_writer
  import s2mm_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = S2MM_WORD_WIDTH,
  parameter int unsigned ADDR_WIDTH = S2MM_ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH  = S2MM_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [LEN_WIDTH-1:0]  i_cmd_len,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  input  logic [WORD_WIDTH-1:0] i_s_data,
  input  logic                  i_s_last,
  output logic                  o_wr_valid,
  input  logic                  i_wr_ready,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [WORD_WIDTH-1:0] o_wr_data,
  output logic                  o_done,
  output logic                  o_err
);

  s2mm_state_e           state_r;
  s2mm_state_e           state_next_s;

  logic                  cmd_ready_s;
  logic                  s_ready_s;
  logic                  done_next_s;

  logic                  cmd_fire_s;
  logic                  beat_fire_s;
  logic                  wr_fire_s;
  logic                  len_zero_s;
  logic                  rem_one_s;
  logic                  end_beat_s;

  logic [ADDR_WIDTH-1:0] cnt_addr_s;
  logic [LEN_WIDTH-1:0]  cnt_rem_s;
  logic                  cnt_zero_s;

  logic                  wr_valid_r;
  logic [ADDR_WIDTH-1:0] wr_addr_r;
  logic [WORD_WIDTH-1:0] wr_data_r;
  logic                  done_r;

  assign cmd_fire_s  = i_cmd_valid && cmd_ready_s;
  assign beat_fire_s = i_s_valid && s_ready_s;
  assign wr_fire_s   = wr_valid_r && i_wr_ready;
  assign len_zero_s  = (i_cmd_len == {LEN_WIDTH{1'b0}});
  assign rem_one_s   = (cnt_rem_s == {{(LEN_WIDTH-1){1'b0}}, 1'b1});

  s2mm_addr_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_addr_counter (
    .clk       (clk),
    .reset     (reset),
    .load      (cmd_fire_s),
    .load_addr (i_cmd_addr),
    .load_len  (i_cmd_len),
    .step      (beat_fire_s),
    .addr      (cnt_addr_s),
    .remaining (cnt_rem_s),
    .zero      (cnt_zero_s)
  );

`ifdef S2MM_LAST_CHECK_EN
  logic last_err_s;
  logic err_r;

  // A beat ends the transfer on the count or on an (early) last marker.
  assign end_beat_s = rem_one_s || i_s_last;
  // Framing error: last marker and final counted word disagree.
  assign last_err_s = i_s_last ^ rem_one_s;

  // Sticky error flag, cleared when the next command is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (cmd_fire_s) begin
      err_r <= 1'b0;
    end else if (beat_fire_s && last_err_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign o_err = err_r;
`else
  logic unused_last_s;

  assign end_beat_s    = rem_one_s;
  assign unused_last_s = i_s_last;
  assign o_err         = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; zero-length commands never leave IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_fire_s && !len_zero_s) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (beat_fire_s && end_beat_s) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (wr_fire_s || !wr_valid_r) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs; stream ready follows write backpressure combinationally
  // so a stalled output stage is never overwritten.
  always_comb begin
    cmd_ready_s = 1'b0;
    s_ready_s   = 1'b0;
    done_next_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cmd_ready_s = 1'b1;
        done_next_s = cmd_fire_s && len_zero_s;
      end
      ST_RUN: begin
        s_ready_s = !cnt_zero_s && (!wr_valid_r || i_wr_ready);
      end
      ST_DRAIN: begin
        done_next_s = wr_fire_s || !wr_valid_r;
      end
      default: begin
        cmd_ready_s = 1'b0;
        s_ready_s   = 1'b0;
        done_next_s = 1'b0;
      end
    endcase
  end

  // Single-entry write stage: reload on a beat, else clear on handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_valid_r <= 1'b0;
      wr_addr_r  <= {ADDR_WIDTH{1'b0}};
      wr_data_r  <= {WORD_WIDTH{1'b0}};
      done_r     <= 1'b0;
    end else begin
      done_r <= done_next_s;
      if (beat_fire_s) begin
        wr_valid_r <= 1'b1;
        wr_addr_r  <= cnt_addr_s;
        wr_data_r  <= i_s_data;
      end else if (wr_fire_s) begin
        wr_valid_r <= 1'b0;
      end else begin
        wr_valid_r <= wr_valid_r;
      end
    end
  end

  assign o_cmd_ready = cmd_ready_s;
  assign o_s_ready   = s_ready_s;
  assign o_wr_valid  = wr_valid_r;
  assign o_wr_addr   = wr_addr_r;
  assign o_wr_data   = wr_data_r;
  assign o_done      = done_r;

endmodule

// File: tb/tb_s2mm_writer.sv
// tb_s2mm_writer
// Directed self-checking bench for s2mm_writer. Inputs change on the
// falling edge; a monitor samples 2 time units after each falling edge,
// i.e. the values that the next rising edge will act on.
module tb_s2mm_writer;

  logic        clk;
  logic        reset;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [15:0] i_cmd_addr;
  logic [15:0] i_cmd_len;
  logic        i_s_valid;
  logic        o_s_ready;
  logic [31:0] i_s_data;
  logic        i_s_last;
  logic        o_wr_valid;
  logic        i_wr_ready;
  logic [15:0] o_wr_addr;
  logic [31:0] o_wr_data;
  logic        o_done;
  logic        o_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int cmd_cyc = -1;
  int done_cyc = -1;
  int done_cnt = 0;

  logic [15:0] wa[$];
  logic [31:0] wd[$];
  int          wc[$];
  logic [32:0] src_q[$];

  s2mm_writer dut (
    .clk         (clk),
    .reset       (reset),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_addr  (i_cmd_addr),
    .i_cmd_len   (i_cmd_len),
    .i_s_valid   (i_s_valid),
    .o_s_ready   (o_s_ready),
    .i_s_data    (i_s_data),
    .i_s_last    (i_s_last),
    .o_wr_valid  (o_wr_valid),
    .i_wr_ready  (i_wr_ready),
    .o_wr_addr   (o_wr_addr),
    .o_wr_data   (o_wr_data),
    .o_done      (o_done),
    .o_err       (o_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stream source: presents the head of src_q on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (src_q.size() > 0) begin
        i_s_valid = 1'b1;
        i_s_data  = src_q[0][31:0];
        i_s_last  = src_q[0][32];
      end else begin
        i_s_valid = 1'b0;
        i_s_data  = 32'h0;
        i_s_last  = 1'b0;
      end
    end
  end

  // Monitor: logs handshakes that the upcoming rising edge will perform.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        if (i_cmd_valid && o_cmd_ready) cmd_cyc = cyc;
        if (o_wr_valid && i_wr_ready) begin
          wa.push_back(o_wr_addr);
          wd.push_back(o_wr_data);
          wc.push_back(cyc);
        end
        if (o_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (i_s_valid && o_s_ready && src_q.size() > 0) void'(src_q.pop_front());
      end
      cyc++;
    end
  end

  task automatic clear_log();
    wa.delete(); wd.delete(); wc.delete();
    done_cnt = 0; done_cyc = -1; cmd_cyc = -1;
  endtask

  task automatic push_beats(input logic [31:0] base, input int n, input int last_idx);
    for (int i = 0; i < n; i++) begin
      src_q.push_back({(i == last_idx), base + 32'(i)});
    end
  endtask

  task automatic send_cmd(input logic [15:0] addr, input logic [15:0] len);
    bit acc;
    acc = 1'b0;
    @(negedge clk);
    i_cmd_valid = 1'b1; i_cmd_addr = addr; i_cmd_len = len;
    for (int i = 0; i < 20 && !acc; i++) begin
      #1;
      if (o_cmd_ready) acc = 1'b1;
      @(negedge clk);
    end
    i_cmd_valid = 1'b0;
    n_tests++;
    if (acc !== 1'b1) begin
      n_fail++;
      $display("FAIL cmd_accept: got %0b expected 1", acc);
    end
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if ({o_cmd_ready, o_s_ready, o_wr_valid, o_done, o_err} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b expected 10000",
               {o_cmd_ready, o_s_ready, o_wr_valid, o_done, o_err});
    end
    n_tests++;
    if ({o_wr_addr, o_wr_data} !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 0", {o_wr_addr, o_wr_data});
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    clear_log();
    i_wr_ready = 1'b1;
    push_beats(32'hA0, 4, 3);
    send_cmd(16'h0010, 16'd4);
    wait_done(40);
    n_tests++;
    if (wa.size() !== 4) begin
      n_fail++; $display("FAIL basic_count: got %0d expected 4", wa.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < wa.size()) begin
        n_tests++;
        if (wa[i] !== 16'h0010 + 16'(i) || wd[i] !== 32'hA0 + 32'(i) || wc[i] !== cmd_cyc + 2 + i) begin
          n_fail++;
          $display("FAIL basic_wr%0d: got %h/%h@%0d expected %h/%h@%0d", i, wa[i], wd[i], wc[i],
                   16'h0010 + 16'(i), 32'hA0 + 32'(i), cmd_cyc + 2 + i);
        end
      end
    end
    n_tests++;
    if (done_cnt !== 1 || wc.size() != 4 || done_cyc !== wc[3] + 1) begin
      n_fail++; $display("FAIL basic_done: got cnt %0d cyc %0d expected cnt 1 one after last write", done_cnt, done_cyc);
    end
    n_tests++;
    if (o_err !== 1'b0) begin
      n_fail++; $display("FAIL basic_err: got %b expected 0", o_err);
    end
  endtask

  task automatic test_stall();
    int stalls;
    stalls = 0;
    clear_log();
    i_wr_ready = 1'b1;
    push_beats(32'hA0, 4, 3);
    send_cmd(16'h0010, 16'd4);
    for (int c = 0; c < 60 && done_cnt == 0; c++) begin
      @(negedge clk);
      if (o_wr_valid && o_wr_addr == 16'h0011 && stalls < 3) begin
        i_wr_ready = 1'b0;
        #1;
        n_tests++;
        if (o_wr_data !== 32'hA1 || o_s_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_hold%0d: got data %h s_ready %b expected A1 0", stalls, o_wr_data, o_s_ready);
        end
        stalls++;
      end else begin
        i_wr_ready = 1'b1;
      end
    end
    i_wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (stalls !== 3) begin
      n_fail++; $display("FAIL stall_cycles: got %0d expected 3", stalls);
    end
    n_tests++;
    if (wa.size() !== 4 || done_cnt !== 1) begin
      n_fail++; $display("FAIL stall_count: got %0d writes %0d done expected 4 1", wa.size(), done_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      if (i < wa.size()) begin
        n_tests++;
        if (wa[i] !== 16'h0010 + 16'(i) || wd[i] !== 32'hA0 + 32'(i)) begin
          n_fail++;
          $display("FAIL stall_wr%0d: got %h/%h expected %h/%h", i, wa[i], wd[i], 16'h0010 + 16'(i), 32'hA0 + 32'(i));
        end
      end
    end
  endtask

  task automatic test_len_zero();
    clear_log();
    send_cmd(16'h0020, 16'd0);
    wait_done(10);
    n_tests++;
    if (wa.size() !== 0) begin
      n_fail++; $display("FAIL len0_writes: got %0d expected 0", wa.size());
    end
    n_tests++;
    if (done_cnt !== 1 || done_cyc !== cmd_cyc + 1) begin
      n_fail++; $display("FAIL len0_done: got cnt %0d cyc %0d expected 1 at %0d", done_cnt, done_cyc, cmd_cyc + 1);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_a [4];
    exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000; exp_a[3] = 16'h0001;
    clear_log();
    push_beats(32'hB0, 4, 3);
    send_cmd(16'hFFFE, 16'd4);
    wait_done(40);
    n_tests++;
    if (wa.size() !== 4 || done_cnt !== 1) begin
      n_fail++; $display("FAIL wrap_count: got %0d writes %0d done expected 4 1", wa.size(), done_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      if (i < wa.size()) begin
        n_tests++;
        if (wa[i] !== exp_a[i] || wd[i] !== 32'hB0 + 32'(i)) begin
          n_fail++;
          $display("FAIL wrap_wr%0d: got %h/%h expected %h/%h", i, wa[i], wd[i], exp_a[i], 32'hB0 + 32'(i));
        end
      end
    end
  endtask

  task automatic test_last();
    clear_log();
    src_q.push_back({1'b0, 32'hC0});
    src_q.push_back({1'b1, 32'hC1});
    src_q.push_back({1'b0, 32'hC2});
    src_q.push_back({1'b1, 32'hC3});
    send_cmd(16'h0030, 16'd4);
    wait_done(40);
`ifdef S2MM_LAST_CHECK_EN
    n_tests++;
    if (wa.size() !== 2 || done_cnt !== 1 || o_err !== 1'b1) begin
      n_fail++; $display("FAIL last_early: got %0d writes %0d done err %b expected 2 1 1", wa.size(), done_cnt, o_err);
    end
    if (wa.size() == 2) begin
      n_tests++;
      if (wa[1] !== 16'h0031 || wd[1] !== 32'hC1) begin
        n_fail++; $display("FAIL last_wr1: got %h/%h expected 0031/C1", wa[1], wd[1]);
      end
    end
    clear_log();
    send_cmd(16'h0060, 16'd2);
    wait_done(40);
    n_tests++;
    if (wa.size() !== 2 || done_cnt !== 1 || o_err !== 1'b0) begin
      n_fail++; $display("FAIL last_rest: got %0d writes %0d done err %b expected 2 1 0", wa.size(), done_cnt, o_err);
    end
    if (wa.size() == 2) begin
      n_tests++;
      if (wa[0] !== 16'h0060 || wd[0] !== 32'hC2 || wa[1] !== 16'h0061 || wd[1] !== 32'hC3) begin
        n_fail++; $display("FAIL last_keep: got %h/%h %h/%h expected 0060/C2 0061/C3", wa[0], wd[0], wa[1], wd[1]);
      end
    end
`else
    n_tests++;
    if (wa.size() !== 4 || done_cnt !== 1 || o_err !== 1'b0) begin
      n_fail++; $display("FAIL last_ignored: got %0d writes %0d done err %b expected 4 1 0", wa.size(), done_cnt, o_err);
    end
    if (wa.size() == 4) begin
      n_tests++;
      if (wa[3] !== 16'h0033 || wd[3] !== 32'hC3) begin
        n_fail++; $display("FAIL last_wr3: got %h/%h expected 0033/C3", wa[3], wd[3]);
      end
    end
`endif
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    clear_log();
    i_wr_ready = 1'b0;
    push_beats(32'hD0, 4, 3);
    send_cmd(16'h0040, 16'd4);
    for (int i = 0; i < 10 && !seen; i++) begin
      if (o_wr_valid) seen = 1'b1;
      else @(negedge clk);
    end
    n_tests++;
    if (seen !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_pending: got %b expected 1", seen);
    end
    reset = 1'b1;
    src_q.delete();
    @(negedge clk);
    #1;
    n_tests++;
    if ({o_wr_valid, o_cmd_ready, o_done} !== 3'b010) begin
      n_fail++; $display("FAIL rst_mid_state: got %b expected 010", {o_wr_valid, o_cmd_ready, o_done});
    end
    reset = 1'b0;
    i_wr_ready = 1'b1;
    repeat (4) @(negedge clk);
    n_tests++;
    if (done_cnt !== 0 || wa.size() !== 0) begin
      n_fail++; $display("FAIL rst_mid_quiet: got %0d done %0d writes expected 0 0", done_cnt, wa.size());
    end
    clear_log();
    push_beats(32'hE0, 2, 1);
    send_cmd(16'h0050, 16'd2);
    wait_done(40);
    n_tests++;
    if (wa.size() !== 2 || done_cnt !== 1) begin
      n_fail++; $display("FAIL rst_after_count: got %0d writes %0d done expected 2 1", wa.size(), done_cnt);
    end
    if (wa.size() == 2) begin
      n_tests++;
      if (wa[0] !== 16'h0050 || wd[0] !== 32'hE0 || wa[1] !== 16'h0051 || wd[1] !== 32'hE1) begin
        n_fail++; $display("FAIL rst_after_wr: got %h/%h %h/%h expected 0050/E0 0051/E1", wa[0], wd[0], wa[1], wd[1]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    i_cmd_valid = 1'b0; i_cmd_addr = 16'h0; i_cmd_len = 16'h0;
    i_s_valid = 1'b0; i_s_data = 32'h0; i_s_last = 1'b0;
    i_wr_ready = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_len_zero();
    test_wrap();
    test_last();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
